tristate_rr_bus: RTL

Parametrised multi-channel tristate bus driver: `CHANNELS` requesters share one `WIDTH`-bit tristate bus through a round-robin arbiter. Output enable is registered, and every ownership change inserts a guaranteed high-Z turnaround, so two drivers never overlap. A keeper register holds the last driven value for readers. It replaces the single-enable tristate buffer as the standard bus-sharing primitive in tristate test designs.

---
 rtl/tristate_rr_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/tristate_rr_bus.sv | 112 +++++++++++
 3 files changed

// File: rtl/tristate_rr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tristate_rr_pkg : shared types and width helpers for tristate_rr_bus      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
package tristate_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  // TURNAROUND is limited to 1..7, so the turnaround counter never needs more than 3 bits.
  localparam int c_TURN_W = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting at i_ptr            |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int IDX_W    = 2
) (
  input  logic [CHANNELS-1:0] i_req,
  input  logic [IDX_W-1:0]    i_ptr,
  output logic [CHANNELS-1:0] o_gnt,
  output logic [IDX_W-1:0]    o_idx,
  output logic                o_any
);

  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= CHANNELS) w_j = w_j - CHANNELS;
      if (!o_any && i_req[IDX_W'(w_j)]) begin
        o_any               = 1'b1;
        o_gnt[IDX_W'(w_j)]  = 1'b1;
        o_idx               = IDX_W'(w_j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tristate_rr_bus.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tristate_rr_bus : round-robin shared tristate bus with turnaround/keeper  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tristate_rr_bus
  import tristate_rr_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_BURST  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [CHANNELS-1:0]       gnt,
  inout  wire  [WIDTH-1:0]          bus,
  output logic                      oe,
  output logic [WIDTH-1:0]          rdata,
  output logic [WIDTH-1:0]          keep
);

  localparam int c_IDX_W  = idx_w(CHANNELS);
  localparam int c_BEAT_W = idx_w(MAX_BURST);

  state_t                r_state;
  logic [CHANNELS-1:0]   r_gnt;
  logic                  r_oe;
  logic [c_IDX_W-1:0]    r_owner;
  logic [c_IDX_W-1:0]    r_ptr;
  logic [c_BEAT_W-1:0]   r_beat;
  logic [c_TURN_W-1:0]   r_turn;
  logic [WIDTH-1:0]      r_keep;

  logic [WIDTH-1:0]      w_ch [CHANNELS];
  logic [WIDTH-1:0]      w_din_sel;
  logic [CHANNELS-1:0]   w_arb_gnt;
  logic [c_IDX_W-1:0]    w_arb_idx;
  logic                  w_arb_any;
  logic                  w_arb_now;
  logic                  w_release;
  logic [c_IDX_W-1:0]    w_ptr_nxt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign w_ch[i] = din[i*WIDTH +: WIDTH];
  end

  assign w_din_sel = w_ch[r_owner];

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .IDX_W    (c_IDX_W)
  ) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  // Arbitration happens only in IDLE or on the last turnaround cycle; req is ignored elsewhere.
  assign w_arb_now = (r_state == ST_IDLE) || ((r_state == ST_TURN) && (r_turn == '0));
  assign w_release = !req[r_owner] ||
                     ((MAX_BURST != 0) && (r_beat == c_BEAT_W'(MAX_BURST - 1)));
  assign w_ptr_nxt = (r_owner == c_IDX_W'(CHANNELS - 1)) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_oe    <= 1'b0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_beat  <= '0;
      r_turn  <= '0;
      r_keep  <= '0;
    end else if (w_arb_now) begin
      if (w_arb_any) begin
        r_state <= ST_DRIVE;
        r_gnt   <= w_arb_gnt;
        r_oe    <= 1'b1;
        r_owner <= w_arb_idx;
        r_beat  <= '0;
      end else begin
        r_state <= ST_IDLE;
      end
    end else if (r_state == ST_DRIVE) begin
      r_keep <= w_din_sel;
      if (w_release) begin
        r_state <= ST_TURN;
        r_gnt   <= '0;
        r_oe    <= 1'b0;
        r_ptr   <= w_ptr_nxt;
        r_turn  <= c_TURN_W'(TURNAROUND - 1);
      end else begin
        r_beat  <= r_beat + 1'b1;
      end
    end else begin
      r_turn <= r_turn - 1'b1;
    end
  end

  assign bus   = r_oe ? w_din_sel : {WIDTH{1'bz}};
  assign rdata = r_oe ? bus : r_keep;
  assign gnt   = r_gnt;
  assign oe    = r_oe;
  assign keep  = r_keep;

endmodule
`default_nettype wire
